// File: rtl/depacketizer_router.sv
// depacketizer_router
// Splits one NoC packet per cycle into timestep, ifmap/filter select, filter row
// and payload, then routes ifmap and filter traffic into separate registered
// valid/ready output channels. Filter rows are tracked per set so that a
// completion pulse fires when every row has arrived. Out-of-range filter rows
// are drained and counted as errors.

module depacketizer_router #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ELEMS      = 3,
  parameter  int ROW_BITS   = 2,
  parameter  int NUM_ROWS   = 3,
  parameter  int TS_BITS    = 1,
  parameter  int ERR_W      = 8,
  localparam int PAY_W      = ELEMS * DATA_WIDTH,
  localparam int PKT_W      = TS_BITS + 1 + ROW_BITS + PAY_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PKT_W-1:0]    in_data,
  output logic                ifm_valid,
  input  logic                ifm_ready,
  output logic [PAY_W-1:0]    ifm_data,
  output logic [TS_BITS-1:0]  ifm_ts,
  output logic                flt_valid,
  input  logic                flt_ready,
  output logic [PAY_W-1:0]    flt_data,
  output logic [ROW_BITS-1:0] flt_row,
  output logic [TS_BITS-1:0]  flt_ts,
  output logic                flt_set_done,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam logic [ROW_BITS:0] NUM_ROWS_L = NUM_ROWS[ROW_BITS:0];

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One-hot encoding of a filter row within the NUM_ROWS-wide mask.
  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_BITS-1:0] r);
    logic [NUM_ROWS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (r == ROW_BITS'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Packet field decode (p0: combinational, same cycle as the handshake)
  logic [TS_BITS-1:0]  pkt_ts_p0;
  logic                pkt_flt_p0;
  logic [ROW_BITS-1:0] pkt_row_p0;
  logic [PAY_W-1:0]    pkt_pay_p0;
  logic                row_ok_p0;

  assign pkt_ts_p0  = in_data[TS_BITS-1:0];
  assign pkt_flt_p0 = in_data[TS_BITS];
  assign pkt_row_p0 = in_data[TS_BITS+ROW_BITS:TS_BITS+1];
  assign pkt_pay_p0 = in_data[PKT_W-1 -: PAY_W];
  assign row_ok_p0  = ({1'b0, pkt_row_p0} < NUM_ROWS_L);

  logic                ifm_free;
  logic                flt_free;
  logic                acc_p0;
  logic                acc_ifm_p0;
  logic                acc_flt_p0;
  logic                acc_drop_p0;
  logic [NUM_ROWS-1:0] row_mask;
  logic [NUM_ROWS-1:0] mask_next_p0;
  logic                set_full_p0;

  assign ifm_free = ~ifm_valid | ifm_ready;
  assign flt_free = ~flt_valid | flt_ready;

  // Ready depends on which destination the presented packet targets; bad rows always drain.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (!pkt_flt_p0)    in_ready = ifm_free;
      else if (row_ok_p0) in_ready = flt_free;
      else                in_ready = 1'b1;
    end
  end

  assign acc_p0       = in_valid & in_ready;
  assign acc_ifm_p0   = acc_p0 & ~pkt_flt_p0;
  assign acc_flt_p0   = acc_p0 & pkt_flt_p0 & row_ok_p0;
  assign acc_drop_p0  = acc_p0 & pkt_flt_p0 & ~row_ok_p0;
  assign mask_next_p0 = row_mask | row_onehot(pkt_row_p0);
  assign set_full_p0  = &mask_next_p0;

  // Output registers (p1: one cycle after accept)

  // Ifmap channel register: load on accept, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifm_valid <= 1'b0;
      ifm_data  <= '0;
      ifm_ts    <= '0;
    end else if (acc_ifm_p0) begin
      ifm_valid <= 1'b1;
      ifm_data  <= pkt_pay_p0;
      ifm_ts    <= pkt_ts_p0;
    end else if (ifm_ready) begin
      ifm_valid <= 1'b0;
    end
  end

  // Filter channel register: load on in-range accept, otherwise drop valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flt_valid <= 1'b0;
      flt_data  <= '0;
      flt_row   <= '0;
      flt_ts    <= '0;
    end else if (acc_flt_p0) begin
      flt_valid <= 1'b1;
      flt_data  <= pkt_pay_p0;
      flt_row   <= pkt_row_p0;
      flt_ts    <= pkt_ts_p0;
    end else if (flt_ready) begin
      flt_valid <= 1'b0;
    end
  end

  // Row-set tracking: a completing row clears the mask and pulses set_done alongside its output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_mask     <= '0;
      flt_set_done <= 1'b0;
    end else begin
      flt_set_done <= 1'b0;
      if (acc_flt_p0) begin
        if (set_full_p0) begin
          row_mask     <= '0;
          flt_set_done <= 1'b1;
        end else begin
          row_mask <= mask_next_p0;
        end
      end
    end
  end

  // Drop accounting for out-of-range filter rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (acc_drop_p0) begin
      err_sticky <= 1'b1;
      err_cnt    <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_depacketizer_router.sv
// Testbench for depacketizer_router: directed scenarios plus a random mix, with
// a scoreboard of expected outputs filled as packets are accepted.

module tb_depacketizer_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_data;
  logic        ifm_valid;
  logic        ifm_ready = 1'b1;
  logic [23:0] ifm_data;
  logic        ifm_ts;
  logic        flt_valid;
  logic        flt_ready = 1'b1;
  logic [23:0] flt_data;
  logic [1:0]  flt_row;
  logic        flt_ts;
  logic        flt_set_done;
  logic        err_sticky;
  logic [7:0]  err_cnt;

  depacketizer_router dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_data(ifm_data), .ifm_ts(ifm_ts),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_data(flt_data),
    .flt_row(flt_row), .flt_ts(flt_ts), .flt_set_done(flt_set_done),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  row;
    logic        ts;
    logic        done;
  } exp_t;

  exp_t       ifm_q[$];
  exp_t       flt_q[$];
  int         total = 0;
  int         bad = 0;
  int         done_seen = 0;
  int         done0;
  int         last_wait;
  logic [2:0] exp_mask = '0;
  logic [7:0] exp_err = '0;
  logic       exp_sticky = 1'b0;
  bit         rand_rdy = 1'b0;
  logic       ifm_rdy_set = 1'b1;
  logic       flt_rdy_set = 1'b1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model of what one accepted packet should produce.
  task automatic model_accept(input logic [27:0] pkt);
    exp_t       e;
    logic [2:0] m;
    e.data = pkt[27:4];
    e.ts   = pkt[0];
    e.row  = pkt[3:2];
    e.done = 1'b0;
    if (!pkt[1]) begin
      ifm_q.push_back(e);
    end else if (pkt[3:2] < 2'd3) begin
      m = exp_mask | (3'b001 << pkt[3:2]);
      if (m == 3'b111) begin
        e.done   = 1'b1;
        exp_mask = 3'b000;
      end else begin
        exp_mask = m;
      end
      flt_q.push_back(e);
    end else begin
      exp_sticky = 1'b1;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
  endtask

  // Ready drivers: either held at a set level or randomised each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ifm_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ifm_rdy_set;
      flt_ready = rand_rdy ? 1'($urandom_range(0, 1)) : flt_rdy_set;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Present one packet (called at posedge+2) and hold it until accepted.
  task automatic send(input logic [27:0] pkt);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = pkt;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (!in_ready) chk_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    else model_accept(pkt);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  // One-cycle reset mid-run; outputs must be zero and in_ready low.
  task automatic do_reset();
    sync();
    rst_n = 1'b0;
    ifm_q.delete();
    flt_q.delete();
    exp_mask   = '0;
    exp_err    = '0;
    exp_sticky = 1'b0;
    @(negedge clk);
    chk_eq("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk_eq("rst_ifm_valid", 32'(ifm_valid), 32'd0);
    chk_eq("rst_flt_valid", 32'(flt_valid), 32'd0);
    chk_eq("rst_ifm_data", 32'(ifm_data), 32'd0);
    chk_eq("rst_flt_data", 32'(flt_data), 32'd0);
    chk_eq("rst_flt_row", 32'(flt_row), 32'd0);
    chk_eq("rst_ts", 32'({ifm_ts, flt_ts}), 32'd0);
    chk_eq("rst_done", 32'(flt_set_done), 32'd0);
    chk_eq("rst_err", 32'({err_sticky, err_cnt}), 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  // Output monitor: compares each output word against the scoreboard.
  initial begin
    exp_t e;
    logic prev_fv;
    logic prev_fhs;
    logic fresh;
    prev_fv  = 1'b0;
    prev_fhs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_fv  = 1'b0;
        prev_fhs = 1'b0;
      end else begin
        fresh = flt_valid && (!prev_fv || prev_fhs);
        if (flt_set_done) done_seen++;
        if (fresh) begin
          if (flt_q.size() == 0) chk_eq("flt_unexpected", 32'(flt_q.size()), 32'd1);
          else chk_eq("flt_done", 32'(flt_set_done), 32'(flt_q[0].done));
        end else begin
          chk_eq("done_idle", 32'(flt_set_done), 32'd0);
        end
        if (flt_valid && flt_ready) begin
          if (flt_q.size() == 0) begin
            chk_eq("flt_hs_unexpected", 32'(flt_q.size()), 32'd1);
          end else begin
            e = flt_q.pop_front();
            chk_eq("flt_data", 32'(flt_data), 32'(e.data));
            chk_eq("flt_row", 32'(flt_row), 32'(e.row));
            chk_eq("flt_ts", 32'(flt_ts), 32'(e.ts));
          end
        end
        if (ifm_valid && ifm_ready) begin
          if (ifm_q.size() == 0) begin
            chk_eq("ifm_hs_unexpected", 32'(ifm_q.size()), 32'd1);
          end else begin
            e = ifm_q.pop_front();
            chk_eq("ifm_data", 32'(ifm_data), 32'(e.data));
            chk_eq("ifm_ts", 32'(ifm_ts), 32'(e.ts));
          end
        end
        prev_fv  = flt_valid;
        prev_fhs = flt_valid && flt_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("init_in_ready", 32'(in_ready), 32'd0);
    chk_eq("init_valids", 32'({ifm_valid, flt_valid}), 32'd0);
    chk_eq("init_err", 32'({err_sticky, err_cnt}), 32'd0);
    chk_eq("init_done", 32'(flt_set_done), 32'd0);
    sync();
    rst_n = 1'b1;

    // Ifmap routing
    sync();
    send(28'hABCDEF1);
    @(negedge clk);
    chk_eq("t1_ifm_valid", 32'(ifm_valid), 32'd1);
    chk_eq("t1_ifm_data", 32'(ifm_data), 32'hABCDEF);
    chk_eq("t1_ifm_ts", 32'(ifm_ts), 32'd1);
    chk_eq("t1_flt_valid", 32'(flt_valid), 32'd0);

    // Full filter set back-to-back
    sync();
    done0 = done_seen;
    send(28'h1111112);
    send(28'h2222226);
    chk_eq("t2_wait", 32'(last_wait), 32'd0);
    send(28'h333333A);
    chk_eq("t2_wait", 32'(last_wait), 32'd0);
    repeat (3) @(negedge clk);
    chk_eq("t2_done_cnt", 32'(done_seen - done0), 32'd1);

    // Backpressure on the filter channel
    flt_rdy_set = 1'b0;
    sync();
    sync();
    send(28'h123456A);
    fork
      send(28'h654321A);
      begin
        repeat (3) begin
          @(negedge clk);
          chk_eq("t3_hold_valid", 32'(flt_valid), 32'd1);
          chk_eq("t3_hold_data", 32'(flt_data), 32'h123456);
          chk_eq("t3_in_ready", 32'(in_ready), 32'd0);
        end
        flt_rdy_set = 1'b1;
      end
    join
    @(negedge clk);
    chk_eq("t3_second_valid", 32'(flt_valid), 32'd1);
    chk_eq("t3_second_data", 32'(flt_data), 32'h654321);
    repeat (2) @(negedge clk);
    chk_eq("t3_drained", 32'(flt_q.size()), 32'd0);

    // Out-of-range row drop and saturation
    sync();
    send(28'h000000E);
    chk_eq("t4_wait", 32'(last_wait), 32'd0);
    @(negedge clk);
    chk_eq("t4_err_cnt", 32'(err_cnt), 32'd1);
    chk_eq("t4_sticky", 32'(err_sticky), 32'd1);
    chk_eq("t4_flt_valid", 32'(flt_valid), 32'd0);
    sync();
    repeat (300) send(28'h000000E);
    @(negedge clk);
    chk_eq("t4_err_sat", 32'(err_cnt), 32'hFF);
    chk_eq("t4_err_model", 32'(err_cnt), 32'(exp_err));

    // Duplicate row within a set
    do_reset();
    sync();
    done0 = done_seen;
    send(28'hAAAAAA2);
    send(28'hBBBBBB2);
    send(28'hCCCCCC6);
    send(28'hDDDDDDA);
    repeat (3) @(negedge clk);
    chk_eq("t5_done_cnt", 32'(done_seen - done0), 32'd1);
    sync();
    send(28'h4444442);
    send(28'h5555556);
    repeat (3) @(negedge clk);
    chk_eq("t5_mask_cleared", 32'(done_seen - done0), 32'd1);
    sync();
    send(28'h666666A);
    repeat (3) @(negedge clk);
    chk_eq("t5_second_set", 32'(done_seen - done0), 32'd2);

    // Reset in the middle of a set
    do_reset();
    sync();
    send(28'h1010102);
    send(28'h2020206);
    do_reset();
    done0 = done_seen;
    sync();
    send(28'h303030A);
    repeat (3) @(negedge clk);
    chk_eq("t6_no_done", 32'(done_seen - done0), 32'd0);

    // Random mix with random consumer readiness
    rand_rdy = 1'b1;
    sync();
    for (int i = 0; i < 60; i++) begin
      send(28'($urandom));
    end
    rand_rdy = 1'b0;
    repeat (6) @(negedge clk);
    chk_eq("t7_ifm_drained", 32'(ifm_q.size()), 32'd0);
    chk_eq("t7_flt_drained", 32'(flt_q.size()), 32'd0);
    chk_eq("t7_err_cnt", 32'(err_cnt), 32'(exp_err));
    chk_eq("t7_sticky", 32'(err_sticky), 32'(exp_sticky));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
